epmp_bus_cycle: RTL and testbench



---
 rtl/epmp_bus_cycle_if.sv | 29 ++
 rtl/epmp_bus_cycle.sv | 119 +++++++++++
 tb/tb_epmp_bus_cycle.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/epmp_bus_cycle_if.sv
// Sequencer-side request/response signals and the external memory bus of the
// EPMP bus cycle controller, bundled together for one port.
interface epmp_bus_cycle_if;
    logic [15:0] A;
    logic [7:0]  MDR_Out;
    logic        Mem_Rd;
    logic        Mem_Wr;
    logic [7:0]  MDR_In;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] MA;
    logic [7:0]  MD_O;
    logic        MD_OE;
    logic [7:0]  MD_I;
    logic        nRD;
    logic        nWR;
    logic        READY;

    modport slave (
        input  A, MDR_Out, Mem_Rd, Mem_Wr, MD_I, READY,
        output MDR_In, Busy, Done, Err, MA, MD_O, MD_OE, nRD, nWR
    );

    modport master (
        output A, MDR_Out, Mem_Rd, Mem_Wr, MD_I, READY,
        input  MDR_In, Busy, Done, Err, MA, MD_O, MD_OE, nRD, nWR
    );
endinterface

// File: rtl/epmp_bus_cycle.sv
// External memory bus cycle controller: SETUP/ACCESS/HOLD strobe sequence with
// programmable wait states, READY extension and timeout abort.
module epmp_bus_cycle #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    epmp_bus_cycle_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [7:0]  tmo_cnt_reg;
    logic        is_read_reg;
    logic [15:0] ma_reg;
    logic [7:0]  md_o_reg;
    logic        md_oe_reg;
    logic [7:0]  mdr_in_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic        nrd_reg;
    logic        nwr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            is_read_reg  <= 1'b0;
            ma_reg       <= '0;
            md_o_reg     <= '0;
            md_oe_reg    <= 1'b0;
            mdr_in_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            nrd_reg      <= 1'b1;
            nwr_reg      <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Read has priority; a simultaneous write request is dropped.
                    if (bus.Mem_Rd || bus.Mem_Wr) begin
                        state_reg    <= SETUP;
                        busy_reg     <= 1'b1;
                        ma_reg       <= bus.A;
                        is_read_reg  <= bus.Mem_Rd;
                        wait_cnt_reg <= '0;
                        tmo_cnt_reg  <= '0;
                        if (!bus.Mem_Rd) begin
                            md_o_reg  <= bus.MDR_Out;
                            md_oe_reg <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_reg    <= ACCESS;
                    wait_cnt_reg <= WAIT_INIT;
                    tmo_cnt_reg  <= '0;
                    if (is_read_reg) begin
                        nrd_reg <= 1'b0;
                    end else begin
                        nwr_reg <= 1'b0;
                    end
                end
                ACCESS: begin
                    // READY is only looked at once the minimum wait has elapsed.
                    if (wait_cnt_reg != 4'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end else if (bus.READY) begin
                        state_reg <= HOLD;
                        nrd_reg   <= 1'b1;
                        nwr_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        if (is_read_reg) begin
                            mdr_in_reg <= bus.MD_I;
                        end
                    end else if (tmo_cnt_reg == TMO_LIMIT) begin
                        state_reg <= HOLD;
                        nrd_reg   <= 1'b1;
                        nwr_reg   <= 1'b1;
                        err_reg   <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end
                HOLD: begin
                    // Address and write data stay driven through HOLD for hold time.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    md_oe_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.MA     = ma_reg;
    assign bus.MD_O   = md_o_reg;
    assign bus.MD_OE  = md_oe_reg;
    assign bus.MDR_In = mdr_in_reg;
    assign bus.Busy   = busy_reg;
    assign bus.Done   = done_reg;
    assign bus.Err    = err_reg;
    assign bus.nRD    = nrd_reg;
    assign bus.nWR    = nwr_reg;

endmodule

// File: tb/tb_epmp_bus_cycle.sv
// Directed bench for epmp_bus_cycle: reset, read, write, READY extension,
// timeout, request arbitration and back-to-back cycles.
module tb_epmp_bus_cycle;

    localparam int WS  = 1;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    epmp_bus_cycle_if bus();

    epmp_bus_cycle #(
        .WAIT_STATES(WS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int rd_low, wr_low, oe_cnt, done_n, done_j, err_n, err_j, ma_bad, od_bad, end_j;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // j counts edges after the request edge k (j=0 is edge k itself).
    task automatic do_cycle(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [7:0] wdata, input logic [7:0] mdi_base,
                            input bit mdi_vary, input int lo_start, input int lo_end,
                            input bit hold_req);
        rd_low = 0; wr_low = 0; oe_cnt = 0; done_n = 0; done_j = -1;
        err_n = 0; err_j = -1; ma_bad = 0; od_bad = 0; end_j = -1;
        for (int j = 0; j <= 60; j++) begin
            bus.READY = !(j >= lo_start && j < lo_end);
            bus.MD_I  = mdi_base + (mdi_vary ? 8'(j) : 8'd0);
            if (j == 0) begin
                bus.A       = addr;
                bus.MDR_Out = wdata;
                bus.Mem_Rd  = rd;
                bus.Mem_Wr  = wr;
            end
            tick;
            if (j == 0) begin
                bus.A       = ~addr;
                bus.MDR_Out = ~wdata;
                if (!hold_req) begin
                    bus.Mem_Rd = 1'b0;
                    bus.Mem_Wr = 1'b0;
                end
            end
            if (bus.nRD == 1'b0) rd_low++;
            if (bus.nWR == 1'b0) wr_low++;
            if (bus.MD_OE) begin
                oe_cnt++;
                if (bus.MD_O !== wdata) od_bad++;
            end
            if (bus.Busy && bus.MA !== addr) ma_bad++;
            if (bus.Done) begin done_n++; done_j = j; end
            if (bus.Err)  begin err_n++;  err_j  = j; end
            end_j = j;
            if (!bus.Busy) break;
        end
        $display("cycle rd=%0b wr=%0b A=%h: rd_low=%0d wr_low=%0d oe=%0d done=%0d@%0d err=%0d@%0d end=%0d MDR_In=%h",
                 rd, wr, addr, rd_low, wr_low, oe_cnt, done_n, done_j, err_n, err_j, end_j, bus.MDR_In);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.A = '0; bus.MDR_Out = '0; bus.Mem_Rd = 1'b0; bus.Mem_Wr = 1'b0;
        bus.MD_I = '0; bus.READY = 1'b1;

        // Reset state
        tick; tick;
        check("rst Busy",   32'(bus.Busy),   32'd0);
        check("rst Done",   32'(bus.Done),   32'd0);
        check("rst Err",    32'(bus.Err),    32'd0);
        check("rst nRD",    32'(bus.nRD),    32'd1);
        check("rst nWR",    32'(bus.nWR),    32'd1);
        check("rst MD_OE",  32'(bus.MD_OE),  32'd0);
        check("rst MA",     32'(bus.MA),     32'd0);
        check("rst MD_O",   32'(bus.MD_O),   32'd0);
        check("rst MDR_In", 32'(bus.MDR_In), 32'd0);
        rst_n = 1'b1;
        tick;

        // Basic read
        do_cycle(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 0, 0, 1'b0);
        check("rd nRD low",  rd_low, WS + 1);
        check("rd nWR low",  wr_low, 0);
        check("rd MD_OE",    oe_cnt, 0);
        check("rd done cnt", done_n, 1);
        check("rd done lat", done_j, WS + 2);
        check("rd err cnt",  err_n, 0);
        check("rd MA hold",  ma_bad, 0);
        check("rd MDR_In",   32'(bus.MDR_In), 32'hA5);
        check("rd MA idle",  32'(bus.MA), 32'h1234);
        check("rd idle at",  end_j, WS + 3);

        // Basic write
        do_cycle(1'b0, 1'b1, 16'hFFFF, 8'h3C, 8'h00, 1'b0, 0, 0, 1'b0);
        check("wr nWR low",  wr_low, WS + 1);
        check("wr nRD low",  rd_low, 0);
        check("wr MD_OE cyc", oe_cnt, WS + 3);
        check("wr MD_O val", od_bad, 0);
        check("wr done cnt", done_n, 1);
        check("wr done lat", done_j, WS + 2);
        check("wr MA hold",  ma_bad, 0);
        check("wr MD_OE idle", 32'(bus.MD_OE), 32'd0);
        check("wr MDR_In kept", 32'(bus.MDR_In), 32'hA5);

        // READY low 3 cycles after the minimum wait (plus one ignored low cycle during the wait)
        do_cycle(1'b1, 1'b0, 16'h0ABC, 8'h00, 8'h50, 1'b1, WS + 1, WS + 5, 1'b0);
        check("ext nRD low",  rd_low, WS + 1 + 3);
        check("ext done cnt", done_n, 1);
        check("ext done lat", done_j, WS + 2 + 3);
        check("ext MDR_In",   32'(bus.MDR_In), 32'h56);

        // READY stuck low: timeout
        do_cycle(1'b1, 1'b0, 16'h2222, 8'h00, 8'h99, 1'b0, 0, 100, 1'b0);
        check("tmo nRD low",  rd_low, WS + 1 + TMO);
        check("tmo err cnt",  err_n, 1);
        check("tmo err lat",  err_j, WS + 2 + TMO);
        check("tmo done cnt", done_n, 0);
        check("tmo MDR_In",   32'(bus.MDR_In), 32'h56);
        check("tmo idle at",  end_j, WS + 3 + TMO);
        bus.READY = 1'b1;

        // Asynchronous reset mid-ACCESS of a write
        bus.A = 16'hBEEF; bus.MDR_Out = 8'h5A; bus.Mem_Wr = 1'b1;
        tick;
        bus.Mem_Wr = 1'b0;
        tick;
        check("arst pre nWR",  32'(bus.nWR),   32'd0);
        check("arst pre MD_OE", 32'(bus.MD_OE), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst nWR",   32'(bus.nWR),   32'd1);
        check("arst MD_OE", 32'(bus.MD_OE), 32'd0);
        check("arst Busy",  32'(bus.Busy),  32'd0);
        check("arst Done",  32'(bus.Done),  32'd0);
        tick; tick;
        check("arst hold Done", 32'(bus.Done | bus.Err), 32'd0);
        rst_n = 1'b1;
        tick;
        check("arst rel Busy", 32'(bus.Busy), 32'd0);
        check("arst rel Done", 32'(bus.Done), 32'd0);
        check("arst rel nWR",  32'(bus.nWR),  32'd1);

        // Both requests high and held: read wins, held requests ignored while busy
        do_cycle(1'b1, 1'b1, 16'h0042, 8'h77, 8'h3E, 1'b0, 0, 0, 1'b1);
        check("both nRD low",  rd_low, WS + 1);
        check("both nWR low",  wr_low, 0);
        check("both MD_OE",    oe_cnt, 0);
        check("both done cnt", done_n, 1);
        check("both idle at",  end_j, WS + 3);
        check("both MDR_In",   32'(bus.MDR_In), 32'h3E);

        // Request still high: next cycle starts one edge later (period WS+4)
        bus.MD_I = 8'hC3;
        tick;
        check("b2b Busy",  32'(bus.Busy), 32'd1);
        check("b2b MA",    32'(bus.MA),   32'hFFBD);
        for (int i = 0; i < WS + 2; i++) tick;
        check("b2b Done",   32'(bus.Done),   32'd1);
        check("b2b MDR_In", 32'(bus.MDR_In), 32'hC3);
        bus.Mem_Rd = 1'b0;
        bus.Mem_Wr = 1'b0;
        tick;
        check("b2b end Busy", 32'(bus.Busy), 32'd0);
        tick;
        check("b2b quiet",    32'(bus.Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
